// File: rtl/alu_pkg.sv
// Shared encodings for the execute-stage ALU: aluop/funct codes, decoded
// control enum and the multi-cycle FSM state.
package alu_pkg;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_OR    = 2'b11;

  localparam logic [5:0] FUNCT_ADD   = 6'b100000;
  localparam logic [5:0] FUNCT_SUB   = 6'b100010;
  localparam logic [5:0] FUNCT_AND   = 6'b100100;
  localparam logic [5:0] FUNCT_OR    = 6'b100101;
  localparam logic [5:0] FUNCT_XOR   = 6'b100110;
  localparam logic [5:0] FUNCT_NOR   = 6'b100111;
  localparam logic [5:0] FUNCT_SLT   = 6'b101010;
  localparam logic [5:0] FUNCT_SLTU  = 6'b101011;
  localparam logic [5:0] FUNCT_SLL   = 6'b000000;
  localparam logic [5:0] FUNCT_SRL   = 6'b000010;
  localparam logic [5:0] FUNCT_SRA   = 6'b000011;
  localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
  localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
  localparam logic [5:0] FUNCT_MULTU = 6'b011001;
  localparam logic [5:0] FUNCT_DIVU  = 6'b011011;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR, ALU_SLT, ALU_SLTU,
    ALU_SLL, ALU_SRL, ALU_SRA, ALU_MFHI, ALU_MFLO, ALU_MULTU, ALU_DIVU, ALU_ILL
  } alu_ctrl_t;

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

endpackage

// File: rtl/alu_ctrl_dec.sv
// Combinational ALU-control decode from aluop/funct to a control enum,
// flagging multi-cycle ops and undefined function codes.
module alu_ctrl_dec
  import alu_pkg::*;
#(
  parameter bit ENABLE_MULDIV = 1'b1
) (
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  output alu_ctrl_t  ctrl,
  output logic       is_multi,
  output logic       illegal
);

  always_comb begin
    ctrl = ALU_ILL;
    case (aluop)
      ALUOP_ADD: ctrl = ALU_ADD;
      ALUOP_SUB: ctrl = ALU_SUB;
      ALUOP_OR:  ctrl = ALU_OR;
      default: begin
        case (funct)
          FUNCT_ADD:  ctrl = ALU_ADD;
          FUNCT_SUB:  ctrl = ALU_SUB;
          FUNCT_AND:  ctrl = ALU_AND;
          FUNCT_OR:   ctrl = ALU_OR;
          FUNCT_XOR:  ctrl = ALU_XOR;
          FUNCT_NOR:  ctrl = ALU_NOR;
          FUNCT_SLT:  ctrl = ALU_SLT;
          FUNCT_SLTU: ctrl = ALU_SLTU;
          FUNCT_SLL:  ctrl = ALU_SLL;
          FUNCT_SRL:  ctrl = ALU_SRL;
          FUNCT_SRA:  ctrl = ALU_SRA;
          // HI/LO access only exists when the mul/div engine is built
          FUNCT_MFHI:  if (ENABLE_MULDIV) ctrl = ALU_MFHI;
          FUNCT_MFLO:  if (ENABLE_MULDIV) ctrl = ALU_MFLO;
          FUNCT_MULTU: if (ENABLE_MULDIV) ctrl = ALU_MULTU;
          FUNCT_DIVU:  if (ENABLE_MULDIV) ctrl = ALU_DIVU;
          default:    ctrl = ALU_ILL;
        endcase
      end
    endcase
  end

  assign is_multi = (ctrl == ALU_MULTU) || (ctrl == ALU_DIVU);
  assign illegal  = (ctrl == ALU_ILL);

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with registered result, valid/ready input handshake,
// HI/LO registers and an iterative one-bit-per-cycle unsigned mul/div engine.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int WIDTH         = 32,
  parameter int SHAMT_W       = $clog2(WIDTH),
  parameter bit ENABLE_MULDIV = 1'b1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         aluop,
  input  logic [5:0]         funct,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [WIDTH-1:0]   srca,
  input  logic [WIDTH-1:0]   srcb,
  output logic               out_valid,
  output logic [WIDTH-1:0]   result,
  output logic               zero,
  output logic               illegal,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo
);

  alu_ctrl_t          ctrl;
  logic               is_multi;
  logic               dec_illegal;
  state_t             state_reg;
  logic [SHAMT_W-1:0] cnt_reg;
  logic [WIDTH-1:0]   work_hi_reg, work_lo_reg, operand_reg;
  logic [WIDTH-1:0]   result_reg, hi_reg, lo_reg;
  logic               zero_reg, illegal_reg, out_valid_reg;
  logic [WIDTH-1:0]   alu_res;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic               div_ge;
  logic [WIDTH-1:0]   div_diff;
  logic [WIDTH-1:0]   step_hi, step_lo;
  logic               last_step;

  alu_ctrl_dec #(.ENABLE_MULDIV(ENABLE_MULDIV)) u_dec (
    .aluop    (aluop),
    .funct    (funct),
    .ctrl     (ctrl),
    .is_multi (is_multi),
    .illegal  (dec_illegal)
  );

  always_comb begin
    alu_res = '0;
    case (ctrl)
      ALU_ADD:  alu_res = srca + srcb;
      ALU_SUB:  alu_res = srca - srcb;
      ALU_AND:  alu_res = srca & srcb;
      ALU_OR:   alu_res = srca | srcb;
      ALU_XOR:  alu_res = srca ^ srcb;
      ALU_NOR:  alu_res = ~(srca | srcb);
      ALU_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(srca) < $signed(srcb))};
      ALU_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (srca < srcb)};
      ALU_SLL:  alu_res = srcb << shamt;
      ALU_SRL:  alu_res = srcb >> shamt;
      ALU_SRA:  alu_res = WIDTH'($signed(srcb) >>> shamt);
      ALU_MFHI: alu_res = hi_reg;
      ALU_MFLO: alu_res = lo_reg;
      default:  alu_res = '0;
    endcase
  end

  // Multiply: {work_hi,work_lo} holds partial product / remaining multiplier.
  // Divide: work_hi is the running remainder, work_lo shifts dividend out and quotient in.
  always_comb begin
    mul_sum   = {1'b0, work_hi_reg} + (work_lo_reg[0] ? {1'b0, operand_reg} : '0);
    div_shift = {work_hi_reg, work_lo_reg[WIDTH-1]};
    div_ge    = div_shift >= {1'b0, operand_reg};
    div_diff  = div_shift[WIDTH-1:0] - operand_reg;
    if (state_reg == MUL) begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], work_lo_reg[WIDTH-1:1]};
    end else begin
      step_hi = div_ge ? div_diff : div_shift[WIDTH-1:0];
      step_lo = {work_lo_reg[WIDTH-2:0], div_ge};
    end
  end

  assign last_step = (cnt_reg == SHAMT_W'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      work_hi_reg   <= '0;
      work_lo_reg   <= '0;
      operand_reg   <= '0;
      result_reg    <= '0;
      hi_reg        <= '0;
      lo_reg        <= '0;
      zero_reg      <= 1'b0;
      illegal_reg   <= 1'b0;
      out_valid_reg <= 1'b0;
    end else begin
      out_valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            if (is_multi) begin
              state_reg   <= (ctrl == ALU_MULTU) ? MUL : DIV;
              cnt_reg     <= '0;
              work_hi_reg <= '0;
              work_lo_reg <= (ctrl == ALU_MULTU) ? srcb : srca;
              operand_reg <= (ctrl == ALU_MULTU) ? srca : srcb;
            end else begin
              out_valid_reg <= 1'b1;
              result_reg    <= alu_res;
              zero_reg      <= (alu_res == '0);
              illegal_reg   <= dec_illegal;
            end
          end
        end
        default: begin
          work_hi_reg <= step_hi;
          work_lo_reg <= step_lo;
          cnt_reg     <= cnt_reg + 1'b1;
          if (last_step) begin
            state_reg     <= IDLE;
            hi_reg        <= step_hi;
            lo_reg        <= step_lo;
            result_reg    <= step_lo;
            zero_reg      <= (step_lo == '0);
            illegal_reg   <= 1'b0;
            out_valid_reg <= 1'b1;
          end
        end
      endcase
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = out_valid_reg;
  assign result    = result_reg;
  assign zero      = zero_reg;
  assign illegal   = illegal_reg;
  assign hi        = ENABLE_MULDIV ? hi_reg : '0;
  assign lo        = ENABLE_MULDIV ? lo_reg : '0;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: expected results are queued at accept
// time and popped against the DUT whenever out_valid pulses.
module tb_alu_exec_unit;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic [1:0]  aluop;
  logic [5:0]  funct;
  logic [4:0]  shamt;
  logic [31:0] srca, srcb;

  logic        in_ready, out_valid, zero, illegal;
  logic [31:0] result, hi, lo;
  logic        in_ready0, out_valid0, zero0, illegal0;
  logic [31:0] result0, hi0, lo0;

  typedef struct {
    string       tag;
    logic [31:0] result;
    logic        zero;
    logic        illegal;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m_hi, m_lo;
  int          n_checks, n_fail;

  alu_exec_unit #(.WIDTH(32), .ENABLE_MULDIV(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .aluop(aluop), .funct(funct), .shamt(shamt), .srca(srca), .srcb(srcb),
    .out_valid(out_valid), .result(result), .zero(zero), .illegal(illegal),
    .hi(hi), .lo(lo)
  );

  alu_exec_unit #(.WIDTH(32), .ENABLE_MULDIV(1'b0)) dut0 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready0),
    .aluop(aluop), .funct(funct), .shamt(shamt), .srca(srca), .srcb(srcb),
    .out_valid(out_valid0), .result(result0), .zero(zero0), .illegal(illegal0),
    .hi(hi0), .lo(lo0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every out_valid pulse must match the oldest queued op.
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("spurious_out_valid", out_valid, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check({e.tag, "_result"}, result, e.result);
        check({e.tag, "_zero"}, zero, e.zero);
        check({e.tag, "_illegal"}, illegal, e.illegal);
        check({e.tag, "_hi"}, hi, e.hi);
        check({e.tag, "_lo"}, lo, e.lo);
        $display("out %-10s result=%08h zero=%0b illegal=%0b hi=%08h lo=%08h",
                 e.tag, result, zero, illegal, hi, lo);
      end
    end
  end

  // Called at a negedge; returns at the negedge right after the accept edge.
  task automatic send(input logic [1:0] op, input logic [5:0] fn, input logic [4:0] sh,
                      input logic [31:0] a, input logic [31:0] b, input string tag);
    exp_t        e;
    logic [31:0] res;
    logic        ill;
    logic [63:0] prod;
    check({tag, "_ready"}, in_ready, 1);
    in_valid = 1'b1; aluop = op; funct = fn; shamt = sh; srca = a; srcb = b;
    @(posedge clk);
    res = 32'h0; ill = 1'b0;
    case (op)
      2'b00: res = a + b;
      2'b01: res = a - b;
      2'b11: res = a | b;
      default: begin
        case (fn)
          6'b100000: res = a + b;
          6'b100010: res = a - b;
          6'b100100: res = a & b;
          6'b100101: res = a | b;
          6'b100110: res = a ^ b;
          6'b100111: res = ~(a | b);
          6'b101010: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          6'b101011: res = (a < b) ? 32'd1 : 32'd0;
          6'b000000: res = b << sh;
          6'b000010: res = b >> sh;
          6'b000011: res = (b >> sh) | (b[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
          6'b010000: res = m_hi;
          6'b010010: res = m_lo;
          6'b011001: begin
            prod = {32'h0, a} * {32'h0, b};
            m_hi = prod[63:32]; m_lo = prod[31:0]; res = m_lo;
          end
          6'b011011: begin
            if (b == 32'h0) begin m_lo = 32'hFFFF_FFFF; m_hi = a; end
            else begin m_lo = a / b; m_hi = a % b; end
            res = m_lo;
          end
          default: begin res = 32'h0; ill = 1'b1; end
        endcase
      end
    endcase
    e.tag = tag; e.result = res; e.zero = (res == 32'h0); e.illegal = ill;
    e.hi = m_hi; e.lo = m_lo;
    sb.push_back(e);
    $display("in  %-10s aluop=%b funct=%b shamt=%0d a=%08h b=%08h", tag, op, fn, sh, a, b);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(output int busy);
    busy = 0;
    while (in_ready !== 1'b1 && busy < 100) begin
      busy++;
      @(negedge clk);
    end
  endtask

  int busy;

  initial begin
    n_checks = 0; n_fail = 0; m_hi = 0; m_lo = 0;
    reset_n = 1'b0; in_valid = 1'b0; aluop = 2'b00; funct = 6'h0; shamt = 5'h0;
    srca = 32'h0; srcb = 32'h0;
    repeat (2) @(negedge clk);
    check("rst_result", result, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    reset_n = 1'b1;
    @(negedge clk);

    send(2'b10, 6'b100000, 5'd0, 32'd7, 32'd5, "add");
    send(2'b01, 6'b000000, 5'd0, 32'd5, 32'd5, "sub0");
    send(2'b10, 6'b101010, 5'd0, 32'hFFFF_FFFF, 32'd1, "slt");
    send(2'b10, 6'b101011, 5'd0, 32'hFFFF_FFFF, 32'd1, "sltu");
    send(2'b10, 6'b000011, 5'd4, 32'h0, 32'h8000_0000, "sra");
    send(2'b10, 6'b000000, 5'd31, 32'h0, 32'h0000_0003, "sll");
    send(2'b10, 6'b000010, 5'd8, 32'h0, 32'hF000_00F0, "srl");
    send(2'b10, 6'b100100, 5'd0, 32'hF0F0_1234, 32'h0FF0_FF00, "and");
    send(2'b10, 6'b100110, 5'd0, 32'hAAAA_5555, 32'hFFFF_0000, "xor");
    send(2'b10, 6'b100111, 5'd0, 32'h0000_FFFF, 32'h00FF_0000, "nor");
    send(2'b00, 6'b111111, 5'd0, 32'hFFFF_FFFF, 32'd1, "addwrap");
    send(2'b11, 6'b000000, 5'd0, 32'h1200_0000, 32'h0000_0034, "ori");

    // multu: ENABLE_MULDIV=0 copy must flag it illegal without stalling
    send(2'b10, 6'b011001, 5'd0, 32'hFFFF_FFFF, 32'd2, "multu");
    check("nomd_out_valid", out_valid0, 1);
    check("nomd_illegal", illegal0, 1);
    check("nomd_result", result0, 0);
    check("nomd_in_ready", in_ready0, 1);
    check("nomd_hi", hi0, 0);
    wait_idle(busy);
    check("multu_busy", busy, 32);
    send(2'b10, 6'b010010, 5'd0, 32'h0, 32'h0, "mflo");
    send(2'b10, 6'b010000, 5'd0, 32'h0, 32'h0, "mfhi");

    // mid-stream reset held for two edges
    send(2'b00, 6'b000000, 5'd0, 32'd1, 32'd2, "prerst");
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    sb.delete(); m_hi = 0; m_lo = 0;
    check("rst2_result", result, 0);
    check("rst2_out_valid", out_valid, 0);
    check("rst2_in_ready", in_ready, 1);
    check("rst2_hi", hi, 0);
    check("rst2_lo", lo, 0);
    reset_n = 1'b1;
    @(negedge clk);

    send(2'b10, 6'b011011, 5'd0, 32'd100, 32'd7, "divu");
    wait_idle(busy);
    check("divu_busy", busy, 32);
    send(2'b10, 6'b011011, 5'd0, 32'd100, 32'd0, "divu0");
    wait_idle(busy);
    check("divu0_busy", busy, 32);
    send(2'b10, 6'b111111, 5'd0, 32'd9, 32'd9, "illegal");

    // reset during busy cycle 10 of a divu aborts it silently
    send(2'b10, 6'b011011, 5'd0, 32'd1000, 32'd3, "divurst");
    repeat (9) @(negedge clk);
    check("divurst_busy", in_ready, 0);
    sb.delete(); m_hi = 0; m_lo = 0;
    reset_n = 1'b0;
    @(negedge clk);
    check("abort_in_ready", in_ready, 1);
    check("abort_out_valid", out_valid, 0);
    check("abort_hi", hi, 0);
    check("abort_lo", lo, 0);
    reset_n = 1'b1;
    repeat (40) @(negedge clk);
    check("abort_idle", in_ready, 1);
    check("sb_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
